// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer: sizing defaults and the
// RV32I major opcodes the commit logic classifies on.
package reorder_buffer_pkg;

    localparam int DEF_ROB_SIZE  = 16;
    localparam int DEF_ROB_POS_W = 4;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BR     = 7'b1100011,
        OP_L      = 7'b0000011,
        OP_S      = 7'b0100011,
        OP_ARITH  = 7'b0110011,
        OP_ARITHI = 7'b0010011
    } opcode_e;

    // Only branches and JALR can redirect fetch at commit.
    function automatic logic is_mispredict(input logic [6:0] opcode,
                                           input logic       pred_jump,
                                           input logic       real_jump);
        return ((opcode == OP_BR) || (opcode == OP_JALR)) && (pred_jump != real_jump);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order completion window: allocates at tail, commits one ready head entry per cycle (broadcast to commit = 2 edges).
// No internal backpressure: rob_full asserts at ROB_SIZE-1 to cover the decoder's in-flight instruction; rdy=0 freezes all state.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE  = DEF_ROB_SIZE,
    parameter int ROB_POS_W = DEF_ROB_POS_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,

    input  logic                 issue,
    input  logic [4:0]           issue_rd,
    input  logic [6:0]           issue_opcode,
    input  logic [31:0]          issue_pc,
    input  logic                 issue_pred_jump,
    input  logic                 issue_is_ready,
    output logic [ROB_POS_W-1:0] nxt_rob_pos,
    output logic                 rob_full,

    input  logic [ROB_POS_W-1:0] rob_rs1_pos,
    input  logic [ROB_POS_W-1:0] rob_rs2_pos,
    output logic                 rob_rs1_ready,
    output logic                 rob_rs2_ready,
    output logic [31:0]          rob_rs1_val,
    output logic [31:0]          rob_rs2_val,

    input  logic                 alu_result,
    input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
    input  logic [31:0]          alu_result_val,
    input  logic                 alu_result_jump,
    input  logic [31:0]          alu_result_pc,

    input  logic                 lsb_result,
    input  logic [ROB_POS_W-1:0] lsb_result_rob_pos,
    input  logic [31:0]          lsb_result_val,

    output logic                 reg_write,
    output logic [4:0]           reg_rd,
    output logic [31:0]          reg_val,
    output logic [ROB_POS_W-1:0] commit_rob_pos,
    output logic                 lsb_store_commit,
    output logic                 rollback,
    output logic [31:0]          rollback_pc
);

    localparam int CNT_W = ROB_POS_W + 1;

    // Entry control state (reset) and payload (no reset, only read while busy/ready).
    logic                 r_busy      [ROB_SIZE];
    logic                 r_ready     [ROB_SIZE];
    logic [4:0]           r_rd        [ROB_SIZE];
    logic [6:0]           r_opcode    [ROB_SIZE];
    logic                 r_pred_jump [ROB_SIZE];
    logic [31:0]          r_val       [ROB_SIZE];
    logic                 r_real_jump [ROB_SIZE];
    logic [31:0]          r_real_pc   [ROB_SIZE];

    logic [ROB_POS_W-1:0] r_head;
    logic [ROB_POS_W-1:0] r_tail;
    logic [CNT_W-1:0]     r_count;

    logic                 r_reg_write;
    logic [4:0]           r_reg_rd;
    logic [31:0]          r_reg_val;
    logic [ROB_POS_W-1:0] r_commit_rob_pos;
    logic                 r_lsb_store_commit;
    logic                 r_rollback;
    logic [31:0]          r_rollback_pc;

    logic                 w_run;
    logic                 w_commit;
    logic                 w_issue;
    logic                 w_alu_hit;
    logic                 w_lsb_hit;
    logic [6:0]           w_head_op;
    logic                 w_head_mispred;

    // A registered rollback flushes the window, so nothing new is accepted that cycle.
    assign w_run          = rdy && !r_rollback;
    assign w_commit       = (r_count != '0) && r_ready[r_head] && !r_rollback;
    assign w_issue        = issue;
    assign w_alu_hit      = alu_result && r_busy[alu_result_rob_pos];
    assign w_lsb_hit      = lsb_result && r_busy[lsb_result_rob_pos];
    assign w_head_op      = r_opcode[r_head];
    assign w_head_mispred = is_mispredict(w_head_op, r_pred_jump[r_head], r_real_jump[r_head]);

    assign nxt_rob_pos   = r_tail;
    assign rob_full      = (r_count >= CNT_W'(ROB_SIZE - 1));
    assign rob_rs1_ready = r_ready[rob_rs1_pos];
    assign rob_rs2_ready = r_ready[rob_rs2_pos];
    assign rob_rs1_val   = r_val[rob_rs1_pos];
    assign rob_rs2_val   = r_val[rob_rs2_pos];

    assign reg_write        = r_reg_write;
    assign reg_rd           = r_reg_rd;
    assign reg_val          = r_reg_val;
    assign commit_rob_pos   = r_commit_rob_pos;
    assign lsb_store_commit = r_lsb_store_commit;
    assign rollback         = r_rollback;
    assign rollback_pc      = r_rollback_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head             <= '0;
            r_tail             <= '0;
            r_count            <= '0;
            r_reg_write        <= 1'b0;
            r_reg_rd           <= '0;
            r_reg_val          <= '0;
            r_commit_rob_pos   <= '0;
            r_lsb_store_commit <= 1'b0;
            r_rollback         <= 1'b0;
            r_rollback_pc      <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                r_busy[i]  <= 1'b0;
                r_ready[i] <= 1'b0;
            end
        end else if (rdy) begin
            r_reg_write        <= 1'b0;
            r_lsb_store_commit <= 1'b0;
            r_rollback         <= 1'b0;
            if (r_rollback) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                for (int i = 0; i < ROB_SIZE; i++) begin
                    r_busy[i]  <= 1'b0;
                    r_ready[i] <= 1'b0;
                end
            end else begin
                if (w_commit) begin
                    r_busy[r_head]   <= 1'b0;
                    r_head           <= r_head + ROB_POS_W'(1);
                    r_commit_rob_pos <= r_head;
                    if (w_head_op == OP_S) begin
                        r_lsb_store_commit <= 1'b1;
                    end else if (w_head_op != OP_BR) begin
                        r_reg_write <= 1'b1;
                        r_reg_rd    <= r_rd[r_head];
                        r_reg_val   <= r_val[r_head];
                    end
                    if (w_head_mispred) begin
                        r_rollback    <= 1'b1;
                        r_rollback_pc <= r_real_pc[r_head];
                    end
                end
                if (w_alu_hit) begin
                    r_ready[alu_result_rob_pos] <= 1'b1;
                end
                if (w_lsb_hit) begin
                    r_ready[lsb_result_rob_pos] <= 1'b1;
                end
                // Issue last: with a full window the tail slot may be the one just committed.
                if (w_issue) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= issue_is_ready;
                    r_tail          <= r_tail + ROB_POS_W'(1);
                end
                r_count <= r_count + CNT_W'(w_issue) - CNT_W'(w_commit);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_run) begin
            if (w_alu_hit) begin
                r_val[alu_result_rob_pos]       <= alu_result_val;
                r_real_jump[alu_result_rob_pos] <= alu_result_jump;
                r_real_pc[alu_result_rob_pos]   <= alu_result_pc;
            end
            if (w_lsb_hit) begin
                r_val[lsb_result_rob_pos] <= lsb_result_val;
            end
            // real_pc is seeded with the fall-through pc until the ALU resolves it.
            if (w_issue) begin
                r_rd[r_tail]        <= issue_rd;
                r_opcode[r_tail]    <= issue_opcode;
                r_pred_jump[r_tail] <= issue_pred_jump;
                r_val[r_tail]       <= '0;
                r_real_jump[r_tail] <= 1'b0;
                r_real_pc[r_tail]   <= issue_pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: issue/commit, store and branch commit, rollback,
// full/wrap, operand queries, rdy freeze and reset during rollback.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        issue;
    logic [4:0]  issue_rd;
    logic [6:0]  issue_opcode;
    logic [31:0] issue_pc;
    logic        issue_pred_jump, issue_is_ready;
    logic [3:0]  nxt_rob_pos;
    logic        rob_full;
    logic [3:0]  rob_rs1_pos, rob_rs2_pos;
    logic        rob_rs1_ready, rob_rs2_ready;
    logic [31:0] rob_rs1_val, rob_rs2_val;
    logic        alu_result;
    logic [3:0]  alu_result_rob_pos;
    logic [31:0] alu_result_val;
    logic        alu_result_jump;
    logic [31:0] alu_result_pc;
    logic        lsb_result;
    logic [3:0]  lsb_result_rob_pos;
    logic [31:0] lsb_result_val;
    logic        reg_write;
    logic [4:0]  reg_rd;
    logic [31:0] reg_val;
    logic [3:0]  commit_rob_pos;
    logic        lsb_store_commit, rollback;
    logic [31:0] rollback_pc;

    int n_cmp = 0;
    int n_mis = 0;

    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_ARITH = 7'b0110011;
    localparam logic [6:0] OPC_ADDI  = 7'b0010011;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue(issue), .issue_rd(issue_rd), .issue_opcode(issue_opcode),
        .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump), .issue_is_ready(issue_is_ready),
        .nxt_rob_pos(nxt_rob_pos), .rob_full(rob_full),
        .rob_rs1_pos(rob_rs1_pos), .rob_rs2_pos(rob_rs2_pos),
        .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
        .rob_rs1_val(rob_rs1_val), .rob_rs2_val(rob_rs2_val),
        .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos),
        .alu_result_val(alu_result_val), .alu_result_jump(alu_result_jump),
        .alu_result_pc(alu_result_pc),
        .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_result_rob_pos),
        .lsb_result_val(lsb_result_val),
        .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val),
        .commit_rob_pos(commit_rob_pos), .lsb_store_commit(lsb_store_commit),
        .rollback(rollback), .rollback_pc(rollback_pc)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are checked at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue = 1'b0; issue_rd = '0; issue_opcode = '0; issue_pc = '0;
        issue_pred_jump = 1'b0; issue_is_ready = 1'b0;
        alu_result = 1'b0; alu_result_rob_pos = '0; alu_result_val = '0;
        alu_result_jump = 1'b0; alu_result_pc = '0;
        lsb_result = 1'b0; lsb_result_rob_pos = '0; lsb_result_val = '0;
    endtask

    task automatic set_issue(input logic [4:0] rd, input logic [6:0] op, input logic [31:0] pc,
                             input logic pj, input logic rdy_at_issue);
        issue = 1'b1; issue_rd = rd; issue_opcode = op; issue_pc = pc;
        issue_pred_jump = pj; issue_is_ready = rdy_at_issue;
    endtask

    task automatic set_alu(input logic [3:0] pos, input logic [31:0] val,
                           input logic jmp, input logic [31:0] pc);
        alu_result = 1'b1; alu_result_rob_pos = pos; alu_result_val = val;
        alu_result_jump = jmp; alu_result_pc = pc;
    endtask

    task automatic set_lsb(input logic [3:0] pos, input logic [31:0] val);
        lsb_result = 1'b1; lsb_result_rob_pos = pos; lsb_result_val = val;
    endtask

    initial begin
        idle();
        rst = 1'b1; rdy = 1'b1; rob_rs1_pos = '0; rob_rs2_pos = '0;
        tick(); tick();
        rst = 1'b0;
        chk_eq("rst_nxt", nxt_rob_pos, 0);
        chk_eq("rst_full", rob_full, 0);
        chk_eq("rst_regw", reg_write, 0);
        chk_eq("rst_rb", rollback, 0);
        chk_eq("rst_st", lsb_store_commit, 0);
        chk_eq("rst_val", reg_val, 0);

        // addi rd=5 -> ALU result -> commit two edges after the broadcast
        set_issue(5, OPC_ADDI, 32'h100, 0, 0); tick(); idle();
        chk_eq("iss_nxt", nxt_rob_pos, 1);
        chk_eq("iss_q0_rdy", rob_rs1_ready, 0);
        set_alu(0, 7, 0, 32'h104); tick(); idle();
        chk_eq("bc_no_commit", reg_write, 0);
        chk_eq("bc_q0_rdy", rob_rs1_ready, 1);
        chk_eq("bc_q0_val", rob_rs1_val, 7);
        tick();
        chk_eq("cm_regw", reg_write, 1);
        chk_eq("cm_rd", reg_rd, 5);
        chk_eq("cm_val", reg_val, 7);
        chk_eq("cm_pos", commit_rob_pos, 0);
        tick();
        chk_eq("cm_pulse", reg_write, 0);

        // store ready at issue, pos1
        set_issue(0, OPC_S, 32'h104, 0, 1); tick(); idle();
        chk_eq("st_early", lsb_store_commit, 0);
        tick();
        chk_eq("st_commit", lsb_store_commit, 1);
        chk_eq("st_regw", reg_write, 0);
        chk_eq("st_pos", commit_rob_pos, 1);
        tick();
        chk_eq("st_pulse", lsb_store_commit, 0);

        // mispredicted branch at pos2
        set_issue(0, OPC_BR, 32'h108, 0, 0); tick(); idle();
        set_alu(2, 0, 1, 32'h200); tick(); idle();
        tick();
        chk_eq("br_rb", rollback, 1);
        chk_eq("br_rbpc", rollback_pc, 32'h200);
        chk_eq("br_regw", reg_write, 0);
        chk_eq("br_pos", commit_rob_pos, 2);
        set_issue(7, OPC_ADDI, 32'h10C, 0, 1); tick(); idle();
        chk_eq("rb_clr_rb", rollback, 0);
        chk_eq("rb_nxt", nxt_rob_pos, 0);
        chk_eq("rb_q0_rdy", rob_rs1_ready, 0);
        tick();
        chk_eq("rb_drop_nxt", nxt_rob_pos, 0);
        chk_eq("rb_drop_regw", reg_write, 0);

        // fill: pos i gets rd=i+1, no results
        for (int i = 0; i < 4; i++) begin
            set_issue(5'(i + 1), OPC_ARITH, 32'h300, 0, 0); tick();
        end
        idle();
        rob_rs1_pos = 3; rob_rs2_pos = 3;
        chk_eq("q3_pre_rdy", rob_rs1_ready, 0);
        set_lsb(3, 32'hDEADBEEF); tick(); idle();
        chk_eq("q3_rdy", rob_rs1_ready, 1);
        chk_eq("q3_val", rob_rs1_val, 32'hDEADBEEF);
        chk_eq("q3_rs2_val", rob_rs2_val, 32'hDEADBEEF);
        chk_eq("q3_no_commit", reg_write, 0);
        for (int i = 4; i < 14; i++) begin
            set_issue(5'(i + 1), OPC_ARITH, 32'h300, 0, 0); tick();
        end
        idle();
        chk_eq("cnt14_full", rob_full, 0);
        chk_eq("cnt14_nxt", nxt_rob_pos, 14);
        set_issue(15, OPC_ARITH, 32'h300, 0, 0); tick(); idle();
        chk_eq("cnt15_full", rob_full, 1);
        chk_eq("cnt15_nxt", nxt_rob_pos, 15);

        // two broadcasts same edge, then commit + issue same edge
        set_alu(0, 11, 0, 0); set_lsb(1, 22); tick(); idle();
        set_issue(9, OPC_ARITH, 32'h400, 0, 0); tick(); idle();
        chk_eq("wrap_regw", reg_write, 1);
        chk_eq("wrap_rd", reg_rd, 1);
        chk_eq("wrap_val", reg_val, 11);
        chk_eq("wrap_pos", commit_rob_pos, 0);
        chk_eq("wrap_nxt", nxt_rob_pos, 0);
        chk_eq("wrap_full", rob_full, 1);
        tick();
        chk_eq("c1_rd", reg_rd, 2);
        chk_eq("c1_val", reg_val, 22);
        chk_eq("c1_pos", commit_rob_pos, 1);
        chk_eq("c1_full", rob_full, 0);

        // rdy low: issue and broadcast pending, everything holds
        rdy = 1'b0;
        set_issue(20, OPC_ARITH, 32'h500, 0, 1); set_alu(2, 5, 0, 0);
        rob_rs1_pos = 2;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("frz_regw", reg_write, 1);
            chk_eq("frz_rd", reg_rd, 2);
            chk_eq("frz_nxt", nxt_rob_pos, 0);
            chk_eq("frz_q2_rdy", rob_rs1_ready, 0);
        end
        rdy = 1'b1; idle(); tick();
        chk_eq("unfrz_regw", reg_write, 0);
        chk_eq("unfrz_nxt", nxt_rob_pos, 0);

        // broadcast to a committed (non-busy) slot is ignored
        rob_rs1_pos = 1;
        set_alu(1, 99, 0, 0); tick(); idle();
        chk_eq("nonbusy_val", rob_rs1_val, 22);

        // reset mid-operation, then JALR mispredict and reset during rollback
        rst = 1'b1; tick(); rst = 1'b0;
        chk_eq("rst2_nxt", nxt_rob_pos, 0);
        chk_eq("rst2_full", rob_full, 0);
        set_issue(1, OPC_JALR, 32'h100, 0, 0); tick(); idle();
        set_alu(0, 32'h104, 1, 32'h300); tick(); idle();
        tick();
        chk_eq("jalr_regw", reg_write, 1);
        chk_eq("jalr_rd", reg_rd, 1);
        chk_eq("jalr_val", reg_val, 32'h104);
        chk_eq("jalr_rb", rollback, 1);
        chk_eq("jalr_rbpc", rollback_pc, 32'h300);
        rst = 1'b1; set_issue(3, OPC_ADDI, 32'h300, 0, 1); tick(); rst = 1'b0; idle();
        chk_eq("rstrb_rb", rollback, 0);
        chk_eq("rstrb_rbpc", rollback_pc, 0);
        chk_eq("rstrb_regw", reg_write, 0);
        chk_eq("rstrb_rd", reg_rd, 0);
        chk_eq("rstrb_val", reg_val, 0);
        chk_eq("rstrb_nxt", nxt_rob_pos, 0);
        tick();
        chk_eq("rstrb_drop_nxt", nxt_rob_pos, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
